fft_stage_feeder: RTL and testbench
===================================

FFT_STAGE_FEEDER -- requirements
Module: fft_stage_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 9, bit width of each signed I/Q sample on every port.
REQ-002 Parameter IN_SIZE, default 16, number of parallel lanes per block.
REQ-003 Parameter DEPTH, default 16, number of butterfly results per burst and number of diff blocks buffered.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 bfly_valid  input  1  sum/diff vectors valid this cycle.
REQ-007 bfly_ready  output  1  high when the block accepts a butterfly result; low throughout DRAIN.
REQ-008 sum_i, sum_q  input  signed DATA_WIDTH x [0:IN_SIZE-1]  butterfly upper outputs.
REQ-009 diff_i, diff_q  input  signed DATA_WIDTH x [0:IN_SIZE-1]  butterfly lower outputs, twiddle already applied.
REQ-010 dout_i, dout_q  output  signed DATA_WIDTH x [0:IN_SIZE-1]  block stream to the next stage's delay line.
REQ-011 dout_valid  output  1  drives the next stage's din_valid.
REQ-012 drop_err  output  1  sticky flag, set when a result is presented while bfly_ready is low.
REQ-013 ovf_cnt  output  8  count of dropped results (see Configuration).

Function
REQ-014 The block SHALL implement states IDLE, FILL, DRAIN.
REQ-015 An accept SHALL occur on any cycle where bfly_valid and bfly_ready are both high.
REQ-016 On each accept, the block SHALL register sum_i/sum_q to dout_i/dout_q with dout_valid high on the next cycle (latency 1).
REQ-017 On each accept, the block SHALL write diff_i/diff_q into the DEPTH-entry block FIFO at the write pointer, then increment the pointer.
REQ-018 IDLE->FILL SHALL occur on the first accept; gaps in bfly_valid during FILL are allowed, with dout_valid low on the cycle after each gap cycle.
REQ-019 FILL->DRAIN SHALL occur on the cycle after the DEPTH-th accept; bfly_ready SHALL go low on that same following cycle.
REQ-020 In DRAIN, the block SHALL emit stored diff blocks oldest-first, one per cycle, for exactly DEPTH contiguous cycles, with dout_valid high.
REQ-021 The first DRAIN output SHALL appear on the cycle immediately after the DEPTH-th sum output, with no bubble.
REQ-022 After the last diff block, the block SHALL return to IDLE, reset its pointers and count, and raise bfly_ready.
REQ-023 When bfly_valid is high while bfly_ready is low, the block SHALL discard the data, set drop_err, and leave FIFO, count and output unaffected.
REQ-024 When DRAIN is not emitting and no accept occurred in the previous cycle, dout_valid SHALL be 0 and dout_i/dout_q SHALL hold their last values.
REQ-025 The block SHALL copy data unchanged, with no width growth, rounding or saturation.

Reset
REQ-026 On rstn low, the block SHALL asynchronously enter IDLE with bfly_ready=1, dout_valid=0, all dout lanes=0, drop_err=0, ovf_cnt=0, pointers and count=0, and FIFO contents=0.
REQ-027 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the burst with no residual output after release.

Configuration
REQ-028 With FEEDER_OVF_CNT_EN defined, ovf_cnt SHALL increment on each dropped result and saturate at 255.
REQ-029 Without FEEDER_OVF_CNT_EN, ovf_cnt SHALL be tied to 0 and no counter logic SHALL be present; drop_err behaviour is unchanged.

Structure
REQ-030 A shared package fft_pkg SHALL hold the DATA_WIDTH/IN_SIZE defaults, the I/Q lane-vector typedefs and the feeder_state_t enum.
REQ-031 The DEPTH x IN_SIZE diff storage SHALL be a sub-module blk_fifo (write-enable, read-enable, clear, registered read); the FSM, counters and output mux SHALL stay in fft_stage_feeder.

Verification
REQ-032 16 contiguous accepts with sum lane0=k and diff lane0=100+k (k=0..15) SHALL produce 32 contiguous dout_valid cycles with lane0 = 0..15, then 100..115.
REQ-033 Accepts with a 3-cycle gap after k=5 SHALL delay the drain, and diff output SHALL still start one cycle after sum 15 and appear in order 100..115.
REQ-034 bfly_valid held high for 20 cycles SHALL give bfly_ready low for cycles 17-32, drop_err=1, and ovf_cnt=4 (0 when built without FEEDER_OVF_CNT_EN).
REQ-035 rstn pulsed low during the 5th DRAIN cycle SHALL immediately force dout_valid=0 and bfly_ready=1, and the next burst SHALL output only new data.
REQ-036 Lanes at extremes (-256, +255 for DATA_WIDTH=9) on all 16 lanes SHALL pass bit-exact through both the sum and diff paths.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT sample widths, I/Q lane-vector types and feeder state encoding
package fft_pkg;
  localparam int FFT_DATA_WIDTH = 9;
  localparam int FFT_IN_SIZE = 16;
  typedef logic signed [FFT_DATA_WIDTH-1:0] sample_t;
  typedef sample_t lane_vec_t [FFT_IN_SIZE];
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} feeder_state_t;
endpackage

// File: rtl/fft_stage_feeder_blk_fifo.sv
// blk_fifo: DEPTH-entry buffer of I/Q lane vectors with registered read and pointer clear
module blk_fifo #(
  parameter int DW = 9,
  parameter int LANES = 16,
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic                 clr,
  input  logic signed [DW-1:0] wr_re [LANES],
  input  logic signed [DW-1:0] wr_im [LANES],
  output logic signed [DW-1:0] rd_re [LANES],
  output logic signed [DW-1:0] rd_im [LANES]
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic signed [DW-1:0] mem_re_q [DEPTH][LANES];
  logic signed [DW-1:0] mem_im_q [DEPTH][LANES];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int d = 0; d < DEPTH; d++)
        for (int l = 0; l < LANES; l++) begin
          mem_re_q[d][l] <= '0;
          mem_im_q[d][l] <= '0;
        end
      for (int l = 0; l < LANES; l++) begin
        rd_re[l] <= '0;
        rd_im[l] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_re_q[wr_ptr_q] <= wr_re;
        mem_im_q[wr_ptr_q] <= wr_im;
      end
      if (rd_en) begin
        rd_re <= mem_re_q[rd_ptr_q];
        rd_im <= mem_im_q[rd_ptr_q];
      end
      wr_ptr_q <= clr ? '0 : !wr_en ? wr_ptr_q : wr_ptr_q == PW'(DEPTH-1) ? '0 : wr_ptr_q + 1'b1;
      rd_ptr_q <= clr ? '0 : !rd_en ? rd_ptr_q : rd_ptr_q == PW'(DEPTH-1) ? '0 : rd_ptr_q + 1'b1;
    end
endmodule

// File: rtl/fft_stage_feeder.sv
// fft_stage_feeder: streams butterfly sums, buffers diffs and drains them back-to-back; FEEDER_OVF_CNT_EN adds a saturating drop counter
module fft_stage_feeder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int IN_SIZE = FFT_IN_SIZE,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         bfly_valid,
  output logic                         bfly_ready,
  input  logic signed [DATA_WIDTH-1:0] sum_i [IN_SIZE],
  input  logic signed [DATA_WIDTH-1:0] sum_q [IN_SIZE],
  input  logic signed [DATA_WIDTH-1:0] diff_i [IN_SIZE],
  input  logic signed [DATA_WIDTH-1:0] diff_q [IN_SIZE],
  output logic signed [DATA_WIDTH-1:0] dout_i [IN_SIZE],
  output logic signed [DATA_WIDTH-1:0] dout_q [IN_SIZE],
  output logic                         dout_valid,
  output logic                         drop_err,
  output logic [7:0]                   ovf_cnt
);
  localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  feeder_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic acc, drop, last, rd_en, clr, acc_q, emit_q, src_q, drop_err_q;
  logic signed [DATA_WIDTH-1:0] sum_re_q [IN_SIZE], sum_im_q [IN_SIZE];
  logic signed [DATA_WIDTH-1:0] fifo_re [IN_SIZE], fifo_im [IN_SIZE];
  assign bfly_ready = state_q != DRAIN;
  assign acc = bfly_valid & bfly_ready;
  assign drop = bfly_valid & ~bfly_ready;
  assign last = cnt_q == CW'(DEPTH-1);
  // cnt counts accepts while filling and reads while draining
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rd_en = 1'b0;
    clr = 1'b0;
    if (state_q == DRAIN) begin
      rd_en = 1'b1;
      clr = last;
      state_d = last ? IDLE : DRAIN;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end else if (acc) begin
      state_d = last ? DRAIN : FILL;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= 1'b0;
      emit_q <= 1'b0;
      src_q <= 1'b0;
      drop_err_q <= 1'b0;
      for (int l = 0; l < IN_SIZE; l++) begin
        sum_re_q[l] <= '0;
        sum_im_q[l] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc;
      emit_q <= rd_en;
      src_q <= acc ? 1'b0 : rd_en ? 1'b1 : src_q;
      drop_err_q <= drop_err_q | drop;
      if (acc) begin
        sum_re_q <= sum_i;
        sum_im_q <= sum_q;
      end
    end
  blk_fifo #(.DW(DATA_WIDTH), .LANES(IN_SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .wr_en (acc),
    .rd_en (rd_en),
    .clr   (clr),
    .wr_re (diff_i),
    .wr_im (diff_q),
    .rd_re (fifo_re),
    .rd_im (fifo_im)
  );
  // the fifo read register holds its last entry, so the mux source alone keeps dout stable when idle
  for (genvar l = 0; l < IN_SIZE; l++) begin : g_out
    assign dout_i[l] = src_q ? fifo_re[l] : sum_re_q[l];
    assign dout_q[l] = src_q ? fifo_im[l] : sum_im_q[l];
  end
  assign dout_valid = acc_q | emit_q;
  assign drop_err = drop_err_q;
`ifdef FEEDER_OVF_CNT_EN
  logic [7:0] ovf_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) ovf_q <= '0;
    else ovf_q <= (drop && ovf_q != 8'hff) ? ovf_q + 1'b1 : ovf_q;
  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_fft_stage_feeder.sv
// tb_fft_stage_feeder: directed checks of sum/diff streaming, gaps, drops, mid-drain reset and extreme lanes
module tb_fft_stage_feeder;
  import fft_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic bfly_valid = 1'b0;
  logic bfly_ready, dout_valid, drop_err;
  logic [7:0] ovf_cnt;
  lane_vec_t sum_i, sum_q, diff_i, diff_q, dout_i, dout_q;
  int checks = 0;
  int errors = 0;
  int exp_ovf;
  logic ok;
  always #5 clk = ~clk;
  fft_stage_feeder #(.DATA_WIDTH(9), .IN_SIZE(16), .DEPTH(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bfly_valid (bfly_valid),
    .bfly_ready (bfly_ready),
    .sum_i      (sum_i),
    .sum_q      (sum_q),
    .diff_i     (diff_i),
    .diff_q     (diff_q),
    .dout_i     (dout_i),
    .dout_q     (dout_q),
    .dout_valid (dout_valid),
    .drop_err   (drop_err),
    .ovf_cnt    (ovf_cnt)
  );
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input int s, input int d);
    bfly_valid = v;
    for (int j = 0; j < 16; j++) begin
      sum_i[j] = sample_t'(s + j);
      sum_q[j] = sample_t'(-s - j);
      diff_i[j] = sample_t'(d + j);
      diff_q[j] = sample_t'(-d - j);
    end
  endtask
  task automatic expect_out(input string tag, input int base);
    chk({tag, "_valid"}, dout_valid, 1);
    chk({tag, "_i0"}, dout_i[0], base);
    chk({tag, "_q15"}, dout_q[15], -base - 15);
  endtask
  function automatic sample_t ext(input int j, input int k, input int inv);
    return (((j + k) % 2) ^ inv) != 0 ? sample_t'(255) : sample_t'(-256);
  endfunction
  initial begin
`ifdef FEEDER_OVF_CNT_EN
    exp_ovf = 4;
`else
    exp_ovf = 0;
`endif
    drive(0, 0, 0);
    #12;
    chk("rst_ready", bfly_ready, 1);
    chk("rst_valid", dout_valid, 0);
    chk("rst_i0", dout_i[0], 0);
    chk("rst_q15", dout_q[15], 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_ovf", ovf_cnt, 0);
    rstn = 1'b1;
    // contiguous burst: sums then diffs with no bubble
    for (int k = 0; k < 16; k++) begin
      drive(1, k, 100 + k);
      chk("t1_ready", bfly_ready, 1);
      tick;
      expect_out("t1_sum", k);
    end
    drive(0, 0, 0);
    for (int d = 0; d < 16; d++) begin
      tick;
      expect_out("t1_diff", 100 + d);
      chk("t1_ready_drain", bfly_ready, d == 15);
    end
    tick;
    chk("t1_idle_valid", dout_valid, 0);
    chk("t1_hold", dout_i[0], 115);
    // three-cycle gap after k=5
    for (int k = 0; k < 16; k++) begin
      if (k == 6) begin
        drive(0, 0, 0);
        for (int g = 0; g < 3; g++) begin
          tick;
          chk("t2_gap_valid", dout_valid, 0);
          chk("t2_gap_hold", dout_i[0], 15);
          chk("t2_gap_ready", bfly_ready, 1);
        end
      end
      drive(1, 10 + k, 120 + k);
      tick;
      expect_out("t2_sum", 10 + k);
    end
    drive(0, 0, 0);
    for (int d = 0; d < 16; d++) begin
      tick;
      expect_out("t2_diff", 120 + d);
    end
    tick;
    chk("t2_idle_valid", dout_valid, 0);
    // valid held for 20 cycles: last 4 are dropped
    for (int c = 1; c <= 20; c++) begin
      drive(1, 30 + c - 1, 150 + c - 1);
      chk("t3_ready", bfly_ready, c <= 16);
      tick;
      if (c <= 16) expect_out("t3_sum", 30 + c - 1);
      else expect_out("t3_diff", 150 + c - 17);
    end
    drive(0, 0, 0);
    for (int c = 21; c <= 33; c++) begin
      chk("t3_ready_tail", bfly_ready, c == 33);
      tick;
      if (c <= 32) expect_out("t3_diff", 150 + c - 17);
      else chk("t3_end_valid", dout_valid, 0);
    end
    chk("t3_drop_err", drop_err, 1);
    chk("t3_ovf", ovf_cnt, exp_ovf);
    rstn = 1'b0;
    #2;
    chk("t4_rst_drop", drop_err, 0);
    chk("t4_rst_ovf", ovf_cnt, 0);
    rstn = 1'b1;
    // reset during the 5th drain cycle
    for (int k = 0; k < 16; k++) begin
      drive(1, 20 + k, 40 + k);
      tick;
      expect_out("t4_sum", 20 + k);
    end
    drive(0, 0, 0);
    for (int d = 0; d < 5; d++) begin
      tick;
      expect_out("t4_diff", 40 + d);
    end
    #2;
    rstn = 1'b0;
    #1;
    chk("t4_mid_valid", dout_valid, 0);
    chk("t4_mid_ready", bfly_ready, 1);
    chk("t4_mid_i0", dout_i[0], 0);
    rstn = 1'b1;
    for (int g = 0; g < 3; g++) begin
      tick;
      chk("t4_no_residual", dout_valid, 0);
    end
    for (int k = 0; k < 16; k++) begin
      drive(1, 60 + k, 80 + k);
      tick;
      expect_out("t4_new_sum", 60 + k);
    end
    drive(0, 0, 0);
    for (int d = 0; d < 16; d++) begin
      tick;
      expect_out("t4_new_diff", 80 + d);
    end
    tick;
    chk("t4_end_valid", dout_valid, 0);
    // extreme values on every lane through both paths
    for (int k = 0; k < 16; k++) begin
      bfly_valid = 1'b1;
      for (int j = 0; j < 16; j++) begin
        sum_i[j] = ext(j, k, 0);
        sum_q[j] = ext(j, k, 1);
        diff_i[j] = ext(j, k, 1);
        diff_q[j] = ext(j, k, 0);
      end
      tick;
      ok = dout_valid === 1'b1;
      for (int j = 0; j < 16; j++)
        ok = ok && dout_i[j] === ext(j, k, 0) && dout_q[j] === ext(j, k, 1);
      chk("t5_ext_sum", ok, 1);
    end
    drive(0, 0, 0);
    for (int d = 0; d < 16; d++) begin
      tick;
      ok = dout_valid === 1'b1;
      for (int j = 0; j < 16; j++)
        ok = ok && dout_i[j] === ext(j, d, 1) && dout_q[j] === ext(j, d, 0);
      chk("t5_ext_diff", ok, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
